// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encoding,
// watchdog default and the read data returned by a timed-out access.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2
    } arb_state_e;

    localparam int          WDOG_TIMEOUT_DEFAULT = 16;
    localparam logic [31:0] TIMEOUT_RDATA        = 32'h0;

endpackage

// File: rtl/mem_port_arbiter_ack.sv
// Ack watchdog: counts ack-less cycles of an outstanding access and pulses
// timeout_o on the TIMEOUT-th such cycle. TIMEOUT = 0 disables it.
module mem_ack_watchdog #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The current cycle is the TIMEOUT-th without an ack when the count of
    // earlier ack-less cycles has reached TIMEOUT-1.
    assign timeout_o = (TIMEOUT != 0) && en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle single-port memory between instruction fetch and
// the MEM stage, data first, stalling the whole pipeline until both are served.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = WDOG_TIMEOUT_DEFAULT,
    parameter int CNT_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              err_o
);

    arb_state_e        state;
    logic              dm_done;
    logic              if_done;
    logic              dm_req;
    logic              in_access;
    logic              wd_timeout;
    logic              complete;
    logic [DATA_W-1:0] resp_data;

    assign dm_req     = dm_read_i | dm_write_i;
    assign stall_o    = (dm_req & ~dm_done) | (if_req_i & ~if_done);
    assign dm_ready_o = dm_done;
    assign if_ready_o = if_done;
    assign in_access  = (state == ST_DATA) || (state == ST_INST);
    assign complete   = in_access & (mem_ack_i | wd_timeout);
    assign resp_data  = mem_ack_i ? mem_rdata_i : DATA_W'(TIMEOUT_RDATA);

    // Held clear while idle, so every new access starts counting from zero.
    mem_ack_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state == ST_IDLE),
        .en_i      (in_access & ~mem_ack_i),
        .timeout_o (wd_timeout)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            dm_done     <= 1'b0;
            if_done     <= 1'b0;
            dm_rdata_o  <= '0;
            if_rdata_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            // The pipeline advances on this edge, so the served set is retired.
            if (!stall_o) begin
                dm_done <= 1'b0;
                if_done <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (dm_req && !dm_done) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dm_write_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                        state       <= ST_DATA;
                    end else if (if_req_i && !if_done) begin
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= if_addr_i;
                        state      <= ST_INST;
                    end
                end
                ST_DATA: begin
                    if (complete) begin
                        mem_req_o <= 1'b0;
                        dm_done   <= 1'b1;
                        if (!mem_we_o) begin
                            dm_rdata_o <= resp_data;
                        end
                        if (!mem_ack_i) begin
                            err_o <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_INST: begin
                    if (complete) begin
                        mem_req_o  <= 1'b0;
                        if_done    <= 1'b1;
                        if_rdata_o <= resp_data;
                        if (!mem_ack_i) begin
                            err_o <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    mem_req_o <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a memory responder with per-access
// ack delays and a transaction-level model of stall length and results.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          if_req_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic [DW-1:0] if_rdata_o;
    logic          if_ready_o;
    logic          dm_read_i = 1'b0;
    logic          dm_write_i = 1'b0;
    logic [AW-1:0] dm_addr_i = '0;
    logic [DW-1:0] dm_wdata_i = '0;
    logic [DW-1:0] dm_rdata_o;
    logic          dm_ready_o;
    logic          stall_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          mem_ack_i = 1'b0;
    logic          err_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_dm_rdata = '0;
    logic [DW-1:0] m_if_rdata = '0;
    logic          m_err      = 1'b0;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO),
        .CNT_W   (5)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ready_o  (if_ready_o),
        .dm_read_i   (dm_read_i),
        .dm_write_i  (dm_write_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ready_o  (dm_ready_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // One pipeline cycle's worth of requests. dd/di are ack delays in cycles
    // after mem_req_o is first seen; a delay beyond TO-1 means the watchdog
    // completes the access instead.
    task automatic run_txn(input bit rd, input bit wr, input bit ifq,
                           input logic [31:0] daddr, input logic [31:0] iaddr,
                           input logic [31:0] wdata, input logic [31:0] drd,
                           input logic [31:0] ird, input int dd, input int di);
        bit dmq;
        int nd, ni, len, k, rises;
        bit prev_req, cur_data;
        dmq  = rd | wr;
        nd   = (dd > TO - 1) ? TO - 1 : dd;
        ni   = (di > TO - 1) ? TO - 1 : di;
        len  = (dmq ? 2 + nd : 0) + (ifq ? 2 + ni : 0);
        if (dmq && !wr) m_dm_rdata = (dd > TO - 1) ? 32'h0 : drd;
        if (ifq)        m_if_rdata = (di > TO - 1) ? 32'h0 : ird;
        if ((dmq && dd > TO - 1) || (ifq && di > TO - 1)) m_err = 1'b1;

        dm_read_i  = rd;
        dm_write_i = wr;
        dm_addr_i  = daddr;
        dm_wdata_i = wdata;
        if_req_i   = ifq;
        if_addr_i  = iaddr;
        k = 0; rises = 0; prev_req = 1'b0; cur_data = 1'b0;

        for (int cyc = 0; cyc <= len; cyc++) begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hDEAD_BEEF;
            if (mem_req_o) begin
                if (!prev_req) begin
                    rises++;
                    k = 0;
                end
                cur_data = dmq && (rises == 1);
                if (k == (cur_data ? dd : di)) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = cur_data ? drd : ird;
                end
                k++;
            end
            prev_req = mem_req_o;
            @(negedge clk_i);
            chk("stall", 32'(stall_o), 32'(cyc < len));
            if (cyc == 0) chk("req_latency", 32'(mem_req_o), 32'h0);
            if (mem_req_o) begin
                chk("mem_addr", mem_addr_o, cur_data ? daddr : iaddr);
                chk("mem_we", 32'(mem_we_o), 32'(cur_data && wr));
                if (cur_data && wr) chk("mem_wdata", mem_wdata_o, wdata);
            end
            if (cyc == len) begin
                chk("dm_ready", 32'(dm_ready_o), 32'(dmq));
                chk("if_ready", 32'(if_ready_o), 32'(ifq));
                chk("dm_rdata", dm_rdata_o, m_dm_rdata);
                chk("if_rdata", if_rdata_o, m_if_rdata);
                chk("err", 32'(err_o), 32'(m_err));
            end
            next_cycle();
        end

        dm_read_i  = 1'b0;
        dm_write_i = 1'b0;
        if_req_i   = 1'b0;
        mem_ack_i  = 1'b0;
        @(negedge clk_i);
        chk("dm_ready_clr", 32'(dm_ready_o), 32'h0);
        chk("if_ready_clr", 32'(if_ready_o), 32'h0);
        chk("stall_idle", 32'(stall_o), 32'h0);
        chk("dm_rdata_hold", dm_rdata_o, m_dm_rdata);
        chk("if_rdata_hold", if_rdata_o, m_if_rdata);
        chk("access_count", rises, 32'(int'(dmq) + int'(ifq)));
        next_cycle();
    endtask

    task automatic run_random(input int n, input int max_delay);
        for (int i = 0; i < n; i++) begin
            run_txn(1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(max_delay, 0), $urandom_range(max_delay, 0));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_mem_req", 32'(mem_req_o), 32'h0);
        chk("rst_mem_we", 32'(mem_we_o), 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        chk("rst_ready", {30'h0, dm_ready_o, if_ready_o}, 32'h0);
        chk("rst_rdata", dm_rdata_o | if_rdata_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        next_cycle();
        rst_i = 1'b1;
        next_cycle();

        run_txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 3, 0);
        run_txn(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 32'hCAFE_F00D, 32'h5555_AAAA, 32'h0, 0, 0);
        run_txn(1'b1, 1'b0, 1'b1, 32'h10, 32'h100, 32'h0, 32'hA5A5_0001, 32'h0000_0093, 1, 1);
        run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0013, 0, 2);
        run_txn(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 32'h0BAD_CAFE, 32'h7777_7777, 32'h0, 2, 0);
        run_random(30, TO - 1);

        run_txn(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 32'h9999_9999, 32'h0, 9, 0);
        run_random(12, TO + 3);

        // Abort an access in flight, then present a late ack.
        dm_read_i = 1'b1;
        dm_addr_i = 32'h200;
        next_cycle();
        @(negedge clk_i);
        chk("mid_req", 32'(mem_req_o), 32'h1);
        next_cycle();
        rst_i = 1'b0;
        next_cycle();
        m_dm_rdata = '0;
        m_if_rdata = '0;
        m_err      = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_req", 32'(mem_req_o), 32'h0);
        chk("mid_rst_ready", 32'(dm_ready_o), 32'h0);
        chk("mid_rst_err", 32'(err_o), 32'h0);
        chk("mid_rst_rdata", dm_rdata_o | if_rdata_o, 32'h0);
        next_cycle();
        rst_i       = 1'b1;
        dm_read_i   = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFEED_FACE;
        next_cycle();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("late_ack_req", 32'(mem_req_o), 32'h0);
        chk("late_ack_ready", 32'(dm_ready_o), 32'h0);
        chk("late_ack_rdata", dm_rdata_o, 32'h0);
        chk("late_ack_stall", 32'(stall_o), 32'h0);
        next_cycle();

        run_txn(1'b1, 1'b0, 1'b1, 32'h20, 32'h104, 32'h0, 32'h0102_0304, 32'h0506_0708, 0, 1);
        run_random(10, TO + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not reach its end");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
